uart_rx: RTL

//  8N1 UART receiver, LSB first. Receive-side counterpart of uart_tx on the same serial link.

---
 rtl/uart_rx_pkg.sv | 14 +
 rtl/uart_rx_if.sv | 23 ++
 rtl/uart_sync2.sv | 23 ++
 rtl/uart_rx.sv | 116 +++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and default bit timing.
package uart_rx_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// CPU-facing polling interface of the UART receiver plus the serial RxD line.
interface uart_rx_if;
  // Handshake: rx_valid is a level that stays high while rx_data holds an unread byte;
  // rx_ack is a single-cycle pulse from the consumer that clears rx_valid, overrun and
  // frame_err in the following cycle unless a new completion sets them in that same cycle.
  logic       rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       overrun;
  logic       frame_err;
  logic       busy;

  modport master (
    output rx, rx_ack,
    input  rx_data, rx_valid, overrun, frame_err, busy
  );

  modport slave (
    input  rx, rx_ack,
    output rx_data, rx_valid, overrun, frame_err, busy
  );
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous bit; the reset value is a parameter.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clock,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clock) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling, single-byte holding register with sticky flags.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic clock,
  input  logic rst,
  uart_rx_if.slave bus,
  output state_t dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic             rx_s;
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_idx_n;
  logic [7:0]       shreg, shreg_n;
  logic [7:0]       rx_data;
  logic             rx_valid, overrun, frame_err;
  logic             done_good, set_fe;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clock (clock),
    .rst   (rst),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CNT_W'(1);
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    done_good = 1'b0;
    set_fe    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = ST_START;
      end
      ST_START: begin
        // A start bit that is high again at its midpoint was a glitch.
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = ST_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      ST_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            done_good = 1'b1;
            state_n   = ST_IDLE;
          end else begin
            set_fe  = 1'b1;
            state_n = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // A line held low must go high before another start bit is accepted.
        cnt_n = '0;
        if (rx_s) state_n = ST_IDLE;
      end
      default: begin
        cnt_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shreg   <= shreg_n;
      if (done_good) rx_data <= shreg;
      // Setting a flag takes priority over the acknowledge clearing it.
      rx_valid  <= done_good | (rx_valid & ~bus.rx_ack);
      overrun   <= (done_good & rx_valid & ~bus.rx_ack) | (overrun & ~bus.rx_ack);
      frame_err <= set_fe | (frame_err & ~bus.rx_ack);
    end
  end

  assign bus.rx_data   = rx_data;
  assign bus.rx_valid  = rx_valid;
  assign bus.overrun   = overrun;
  assign bus.frame_err = frame_err;
  assign bus.busy      = (state != ST_IDLE);
  assign dbg_state     = state;

endmodule
